// File: rtl/snn_inference_sequencer.sv
// snn_inference_sequencer
//
// Runs one spiking-neural-network inference per stored image. A 0->1 edge on
// NEW_IMAGE (seen while idle) starts NUM_TIMESTEPS passes over the image.
// In each pass every pixel is compared against an 8-bit LFSR value to produce
// a rate-coded input spike. Spikes are streamed to the core, and the core's
// per-timestep output spikes are accumulated in saturating per-class
// counters. The class with the highest count (lowest index on ties) is
// reported on INFERED_DIGIT.
//
// Ports
//   ACLK, ARESETN    clock, synchronous active-low reset
//   NEW_IMAGE        level from the slave register; a rising edge starts a run
//   PIX_ADDR         pixel index presented to the image store
//   PIX_DATA         image[PIX_ADDR], combinational, valid in the same cycle
//   SPK_VALID/READY  input-spike handshake, SPK_ADDR = input neuron index
//   TS_END           one-cycle pulse: all spikes of this timestep have been sent
//   CORE_DONE        one-cycle pulse from the core; OUT_SPIKES valid with it
//   COPROCESSOR_RDY  high while idle (result valid)
//   INFERED_DIGIT    winning class, zero-extended, held until the next result
//
// Handshake: SPK_VALID is raised with SPK_ADDR stable and both stay unchanged
// until a cycle in which SPK_READY is also high; the spike is transferred on
// that clock edge. TS_END is never raised while SPK_VALID is high.
module snn_inference_sequencer #(
   parameter int IMAGE_SIZE      = 256,
   parameter int IMAGE_SIZE_BITS = $clog2(IMAGE_SIZE),
   parameter int PIXEL_BITS      = 8,
   parameter int NUM_CLASSES     = 10,
   parameter int NUM_TIMESTEPS   = 16,
   parameter int COUNT_BITS      = 8
) (
   input  logic                       ACLK,
   input  logic                       ARESETN,
   input  logic                       NEW_IMAGE,
   output logic [IMAGE_SIZE_BITS-1:0] PIX_ADDR,
   input  logic [PIXEL_BITS-1:0]      PIX_DATA,
   output logic                       SPK_VALID,
   output logic [IMAGE_SIZE_BITS-1:0] SPK_ADDR,
   input  logic                       SPK_READY,
   output logic                       TS_END,
   input  logic                       CORE_DONE,
   input  logic [NUM_CLASSES-1:0]     OUT_SPIKES,
   output logic                       COPROCESSOR_RDY,
   output logic [7:0]                 INFERED_DIGIT
);

   localparam int T_BITS = (NUM_TIMESTEPS > 1) ? $clog2(NUM_TIMESTEPS) : 1;
   localparam int K_BITS = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;
   localparam logic [COUNT_BITS-1:0] CNT_MAX = '1;
   localparam logic [7:0] LFSR_SEED = 8'hE1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SCAN,
      S_EMIT,
      S_STEP,
      S_WAIT_CORE,
      S_ARGMAX,
      S_DONE
   } state_t;

   state_t                     state, state_nxt;
   logic                       nq;
   logic [IMAGE_SIZE_BITS-1:0] pix;
   logic [7:0]                 lfsr;
   logic [T_BITS-1:0]          t;
   logic [K_BITS-1:0]          k;
   logic [K_BITS-1:0]          best;
   logic [COUNT_BITS-1:0]      best_count;
   logic [COUNT_BITS-1:0]      cnt [NUM_CLASSES];

   logic start, spike, pix_last, t_last, k_last;

   assign start    = NEW_IMAGE && !nq;
   // The LFSR never holds 0, so a zero pixel never spikes and 255 always does.
   assign spike    = (PIX_DATA >= lfsr);
   assign pix_last = (pix == IMAGE_SIZE_BITS'(IMAGE_SIZE - 1));
   assign t_last   = (t == T_BITS'(NUM_TIMESTEPS - 1));
   assign k_last   = (k == K_BITS'(NUM_CLASSES - 1));
   assign PIX_ADDR = pix;

   always_ff @(posedge ACLK) begin
      if (!ARESETN) state <= S_IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt       = state;
      SPK_VALID       = 1'b0;
      TS_END          = 1'b0;
      COPROCESSOR_RDY = 1'b0;
      case (state)
         S_IDLE: begin
            COPROCESSOR_RDY = 1'b1;
            if (start) state_nxt = S_SCAN;
         end
         S_SCAN: begin
            if (spike)         state_nxt = S_EMIT;
            else if (pix_last) state_nxt = S_STEP;
         end
         S_EMIT: begin
            SPK_VALID = 1'b1;
            if (SPK_READY) state_nxt = pix_last ? S_STEP : S_SCAN;
         end
         S_STEP: begin
            TS_END    = 1'b1;
            state_nxt = S_WAIT_CORE;
         end
         S_WAIT_CORE: begin
            if (CORE_DONE) state_nxt = t_last ? S_ARGMAX : S_SCAN;
         end
         S_ARGMAX: begin
            if (k_last) state_nxt = S_DONE;
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge ACLK) begin
      if (!ARESETN) begin
         // nq resets high so a NEW_IMAGE level held through reset is not an edge.
         nq            <= 1'b1;
         pix           <= '0;
         lfsr          <= LFSR_SEED;
         t             <= '0;
         k             <= '0;
         best          <= '0;
         best_count    <= '0;
         SPK_ADDR      <= '0;
         INFERED_DIGIT <= '0;
         for (int i = 0; i < NUM_CLASSES; i++) cnt[i] <= '0;
      end else begin
         nq <= NEW_IMAGE;
         case (state)
            S_IDLE: begin
               if (start) begin
                  pix  <= '0;
                  t    <= '0;
                  // Seeded once per image; the sequence continues across timesteps.
                  lfsr <= LFSR_SEED;
                  for (int i = 0; i < NUM_CLASSES; i++) cnt[i] <= '0;
               end
            end
            S_SCAN: begin
               lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
               if (spike)          SPK_ADDR <= pix;
               else if (!pix_last) pix      <= pix + 1'b1;
            end
            S_EMIT: begin
               if (SPK_READY && !pix_last) pix <= pix + 1'b1;
            end
            S_WAIT_CORE: begin
               if (CORE_DONE) begin
                  for (int i = 0; i < NUM_CLASSES; i++) begin
                     if (OUT_SPIKES[i] && (cnt[i] != CNT_MAX))
                        cnt[i] <= cnt[i] + COUNT_BITS'(1);
                  end
                  pix <= '0;
                  if (t_last) k <= '0;
                  else        t <= t + 1'b1;
               end
            end
            S_ARGMAX: begin
               // Strict compare keeps the lowest index on ties.
               if (k == '0) begin
                  best       <= '0;
                  best_count <= cnt[0];
               end else if (cnt[k] > best_count) begin
                  best       <= k;
                  best_count <= cnt[k];
               end
               k <= k + 1'b1;
            end
            S_DONE: INFERED_DIGIT <= 8'(best);
            default: ;
         endcase
      end
   end

endmodule

// File: doc/snn_inference_sequencer.md
# snn_inference_sequencer

Sequences one SNN inference per image loaded over the AXI4-Lite slave. On a rising edge of NEW_IMAGE it scans the stored image once per timestep, converts each pixel to a stochastic rate-coded input spike, and streams the spikes to the SNN core. It accumulates per-class output spike counts over NUM_TIMESTEPS timesteps, selects the winning class, and reports it back as COPROCESSOR_RDY / INFERED_DIGIT.

## Interface
- IMAGE_SIZE, 256, pixels per image
- IMAGE_SIZE_BITS, $clog2(IMAGE_SIZE), pixel address width
- PIXEL_BITS, 8, pixel width; must be 8 because it matches the LFSR width
- NUM_CLASSES, 10, number of output neurons
- NUM_TIMESTEPS, 16, timesteps per inference; must be ≥1
- COUNT_BITS, 8, width of each saturating class counter

Ports:
- ACLK  in  1  clock
- ARESETN  in  1  reset: ARESETN, synchronous, active-low; clock ACLK
- NEW_IMAGE  in  1  level from the slave register; a 0→1 transition starts an inference
- PIX_ADDR  out  IMAGE_SIZE_BITS  pixel index into the image array
- PIX_DATA  in  PIXEL_BITS  IMAGE[PIX_ADDR], combinational, valid in the same cycle
- SPK_VALID  out  1  input-spike event valid
- SPK_ADDR  out  IMAGE_SIZE_BITS  input neuron index of the spike
- SPK_READY  in  1  core accepts the spike
- TS_END  out  1  one-cycle pulse: all spikes for the current timestep have been sent
- CORE_DONE  in  1  one-cycle pulse: core finished the timestep
- OUT_SPIKES  in  NUM_CLASSES  output neurons that fired; valid with CORE_DONE
- COPROCESSOR_RDY  out  1  high when idle and the result is valid
- INFERED_DIGIT  out  8  winning class, zero-extended

## Operation
- States: IDLE, SCAN, EMIT, STEP, WAIT_CORE, ARGMAX, DONE.
- Edge detect: register nq <= NEW_IMAGE. Reset value of nq is 1, so a level held through reset does not start an inference.
- IDLE: on NEW_IMAGE && !nq:
  - clear all class counters
  - set pix=0, t=0
  - set lfsr=8'hE1
  - go to SCAN
  - Rising edges outside IDLE are ignored, not queued.
- SCAN: PIX_ADDR=pix. spike = (PIX_DATA >= lfsr). The LFSR advances every SCAN cycle: lfsr <= {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}.
  - If spike: go to EMIT and latch SPK_ADDR=pix.
  - Else if pix==IMAGE_SIZE-1: go to STEP.
  - Else: pix++.
- Encoding consequences: the LFSR never reaches 0, so pixel 0 never spikes and pixel 255 always spikes. The LFSR is seeded once per image, not per timestep.
- EMIT: SPK_VALID=1. SPK_ADDR is held stable until SPK_READY. On acceptance: if pix was last, go to STEP; else pix++ and go to SCAN.
- STEP: TS_END=1 for one cycle, then WAIT_CORE.
- WAIT_CORE: CORE_DONE is sampled only in this state. On CORE_DONE:
  - each count[k] with OUT_SPIKES[k]=1 increments, saturating at 2^COUNT_BITS−1
  - if t==NUM_TIMESTEPS−1, go to ARGMAX with k=0
  - else t++, pix=0, go to SCAN
- ARGMAX: one class per cycle, k=0..NUM_CLASSES−1. best updates only if count[k] > best_count (strict), so the lowest index wins ties. best starts at 0 with best_count=count[0].
- DONE: INFERED_DIGIT <= best, then IDLE.
- INFERED_DIGIT holds its last value until the next DONE.

## Timing
- Reset values:
  - COPROCESSOR_RDY=1, INFERED_DIGIT=0
  - SPK_VALID=0, SPK_ADDR=0, TS_END=0, PIX_ADDR=0
  - state=IDLE, counters=0
- Reset mid-operation aborts immediately; outputs take reset values the next cycle.
- Edge sampled in cycle E: COPROCESSOR_RDY is low from E+1, and the first SCAN is in E+1.
- Cost per pixel: a non-spiking pixel takes 1 cycle; a spiking pixel takes 2 cycles when SPK_READY is high, plus 1 cycle per cycle of back-pressure.
- Cost per timestep: 256 + spikes + stall cycles + 1 (STEP) + WAIT_CORE cycles (≥1).
- ARGMAX takes NUM_CLASSES cycles. DONE takes 1 cycle. COPROCESSOR_RDY rises the cycle after DONE.
- Worked example, all-zero image with CORE_DONE in the first WAIT_CORE cycle: COPROCESSOR_RDY is low from E+1 to E+4139 and high at E+4140.
- SPK_VALID is never deasserted without acceptance. TS_END is never asserted while SPK_VALID is high.

## Test plan
- Reset: COPROCESSOR_RDY=1, INFERED_DIGIT=0, SPK_VALID=0, TS_END=0. NEW_IMAGE held high through reset release → no inference starts.
- All-zero image, CORE_DONE one cycle after TS_END, OUT_SPIKES=0 → zero SPK_VALID, exactly 16 TS_END pulses, COPROCESSOR_RDY low E+1..E+4139, INFERED_DIGIT=0.
- All-255 image, SPK_READY=1 → 256 spikes per timestep with SPK_ADDR 0..255 ascending, 4096 in total. Pixel 128 in an otherwise-zero image → spike count matches a reference LFSR model.
- Class selection:
  - OUT_SPIKES bit 7 every timestep, bit 3 on 8 timesteps → INFERED_DIGIT=7.
  - Bits 2 and 5 every timestep → 2 (tie goes to the lower index).
- Saturation and back-pressure:
  - COUNT_BITS=3, bits 1 and 4 every timestep → both counters saturate at 7, INFERED_DIGIT=1.
  - SPK_READY low for 5 cycles → SPK_VALID and SPK_ADDR stable throughout.
- Busy and abort:
  - NEW_IMAGE toggled during SCAN → ignored.
  - ARESETN low mid-SCAN → COPROCESSOR_RDY=1 and SPK_VALID=0 on the next cycle.
  - A fresh NEW_IMAGE 0→1 edge afterwards → full inference completes.
